// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter in front of a register file: one buffer per requester, one write per cycle.
// Define REGWR_ARB_ROUND_ROBIN_EN for round-robin contention handling; default is fixed priority to A.
module regfile_write_arbiter (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        ValidA,
  input  logic [4:0]  AddrA,
  input  logic [63:0] DataA,
  output logic        ReadyA,
  input  logic        ValidB,
  input  logic [4:0]  AddrB,
  input  logic [63:0] DataB,
  output logic        ReadyB,
  output logic        RegWr,
  output logic [4:0]  RW,
  output logic [63:0] BusW,
  output logic [31:0] Pending
);

  localparam logic [4:0] XZR = 5'd31;

  logic        full_a;
  logic [4:0]  addr_a_buf;
  logic [63:0] data_a_buf;
  logic        full_b;
  logic [4:0]  addr_b_buf;
  logic [63:0] data_b_buf;
  logic        grant_a;
  logic        grant_b;
  logic        load_a;
  logic        load_b;

`ifdef REGWR_ARB_ROUND_ROBIN_EN
  // ptr=0 favours A, ptr=1 favours B; only contention moves it.
  logic ptr;

  always_comb begin
    grant_a = full_a & (~full_b | ~ptr);
    grant_b = full_b & (~full_a | ptr);
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)
      ptr <= 1'b0;
    else if (full_a && full_b)
      ptr <= ~ptr;
  end
`else
  always_comb begin
    grant_a = full_a;
    grant_b = full_b & ~full_a;
  end
`endif

  // A buffer being drained this cycle can take a new entry in the same edge.
  assign ReadyA = ~full_a | grant_a;
  assign ReadyB = ~full_b | grant_b;

  // Writes to XZR are handshaken but never stored.
  assign load_a = ValidA & ReadyA & (AddrA != XZR);
  assign load_b = ValidB & ReadyB & (AddrB != XZR);

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      full_a     <= 1'b0;
      addr_a_buf <= '0;
      data_a_buf <= '0;
    end else if (load_a) begin
      full_a     <= 1'b1;
      addr_a_buf <= AddrA;
      data_a_buf <= DataA;
    end else if (grant_a) begin
      full_a     <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      full_b     <= 1'b0;
      addr_b_buf <= '0;
      data_b_buf <= '0;
    end else if (load_b) begin
      full_b     <= 1'b1;
      addr_b_buf <= AddrB;
      data_b_buf <= DataB;
    end else if (grant_b) begin
      full_b     <= 1'b0;
    end
  end

  // RW and BusW hold their last value in idle cycles.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      RegWr <= 1'b0;
      RW    <= '0;
      BusW  <= '0;
    end else if (grant_a) begin
      RegWr <= 1'b1;
      RW    <= addr_a_buf;
      BusW  <= data_a_buf;
    end else if (grant_b) begin
      RegWr <= 1'b1;
      RW    <= addr_b_buf;
      BusW  <= data_b_buf;
    end else begin
      RegWr <= 1'b0;
    end
  end

  always_comb begin
    Pending = '0;
    for (int r = 0; r < 31; r++) begin
      Pending[r] = (full_a && (addr_a_buf == 5'(r))) ||
                   (full_b && (addr_b_buf == 5'(r)));
    end
  end

endmodule
